// File: rtl/frame_streamer_if.sv
// -----------------------------------------------------------------------------
// frame_streamer_if
// Groups the capture-side and replay-side handshake signals of frame_streamer
// into one bundle so the block and its neighbours can be wired with a single
// connection.
//
// Signals (names are as seen from the frame buffer):
//   valid_i / ready_o / data_i        upstream capture stream
//   valid_o / ready_i / data_o        downstream replay stream
//   sof_o / eol_o / eof_o             raster markers travelling with data_o
//   busy_o                            high while a frame is being replayed
//
// Modports:
//   slave  - the frame buffer itself
//   master - whoever drives the capture stream and consumes the replay stream
// -----------------------------------------------------------------------------
interface frame_streamer_if #(
   parameter int WidthIn = 1
);
   logic               valid_i;
   logic               ready_o;
   logic [WidthIn-1:0] data_i;
   logic               valid_o;
   logic               ready_i;
   logic [WidthIn-1:0] data_o;
   logic               sof_o;
   logic               eol_o;
   logic               eof_o;
   logic               busy_o;

   modport slave (
      input  valid_i, data_i, ready_i,
      output ready_o, valid_o, data_o, sof_o, eol_o, eof_o, busy_o
   );

   modport master (
      output valid_i, data_i, ready_i,
      input  ready_o, valid_o, data_o, sof_o, eol_o, eof_o, busy_o
   );
endinterface

// File: rtl/frame_streamer.sv
// -----------------------------------------------------------------------------
// frame_streamer
// Single-frame buffer: captures one LineWidthPx x LineCountPx frame from the
// upstream ready/valid stream, then replays it in raster order downstream with
// sof/eol/eof markers and full backpressure, and returns to capturing.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous, active-low reset
//   bus     frame_streamer_if.slave carrying both streams, markers and busy
// -----------------------------------------------------------------------------
module frame_streamer #(
   parameter int LineWidthPx = 160,
   parameter int LineCountPx = 120,
   parameter int WidthIn     = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   frame_streamer_if.slave  bus
);

   localparam int Depth     = LineWidthPx * LineCountPx;
   localparam int AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int XWidth    = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
   localparam int YWidth    = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;

   localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);
   localparam logic [XWidth-1:0]    LastX    = XWidth'(LineWidthPx - 1);
   localparam logic [YWidth-1:0]    LastY    = YWidth'(LineCountPx - 1);

   typedef enum logic {
      Fill  = 1'b0,
      Drain = 1'b1
   } state_e;

   state_e               state_q;
   logic                 ready_q;
   logic                 busy_q;
   logic [AddrWidth-1:0] waddr_q;
   logic [AddrWidth-1:0] raddr_q;
   logic                 readDone_q;
   logic [XWidth-1:0]    x_q;
   logic [YWidth-1:0]    y_q;

   logic [WidthIn-1:0]   mem [Depth];

   logic [WidthIn-1:0]   fifoData_q [2];
   logic [1:0]           fifoSof_q;
   logic [1:0]           fifoEol_q;
   logic [1:0]           fifoEof_q;
   logic                 wrPtr_q;
   logic                 rdPtr_q;
   logic [1:0]           count_q;
   logic [1:0]           count_d;

   logic                 inFire;
   logic                 outFire;
   logic                 headValid;
   logic                 issue;
   logic                 issueSof;
   logic                 issueEol;
   logic                 issueEof;

   // Handshake decode and read-issue decision. The RAM read lands straight in
   // the output FIFO slot, so "in flight" and "buffered" share one count. A
   // pop in the same cycle frees a slot, which is what keeps the replay at one
   // pixel per clock; with ready_i low the count stops at two reads.
   always_comb begin
      inFire    = bus.valid_i & ready_q;
      headValid = (count_q != 2'd0);
      outFire   = headValid & bus.ready_i;
      issue     = (state_q == Drain) && !readDone_q &&
                  ((count_q != 2'd2) || outFire);
      issueSof  = (x_q == '0) && (y_q == '0);
      issueEol  = (x_q == LastX);
      issueEof  = issueEol && (y_q == LastY);
      count_d   = count_q + 2'(issue) - 2'(outFire);
   end

   // Frame storage write port; only ever written while capturing.
   always_ff @(posedge clk_i) begin
      if (inFire) begin
         mem[waddr_q] <= bus.data_i;
      end
   end

   // Synchronous read port, one cycle of latency, landing in the FIFO tail.
   // Left unreset on purpose: the outputs are gated by the FIFO count.
   always_ff @(posedge clk_i) begin
      if (issue) begin
         fifoData_q[wrPtr_q] <= mem[raddr_q];
      end
   end

   // Capture/replay state machine together with the read-side raster
   // counters and the FIFO bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= Fill;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         waddr_q    <= '0;
         raddr_q    <= '0;
         readDone_q <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         fifoSof_q  <= '0;
         fifoEol_q  <= '0;
         fifoEof_q  <= '0;
         wrPtr_q    <= 1'b0;
         rdPtr_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         count_q <= count_d;

         if (issue) begin
            wrPtr_q            <= ~wrPtr_q;
            fifoSof_q[wrPtr_q] <= issueSof;
            fifoEol_q[wrPtr_q] <= issueEol;
            fifoEof_q[wrPtr_q] <= issueEof;
            if (raddr_q == LastAddr) begin
               readDone_q <= 1'b1;
            end else begin
               raddr_q <= raddr_q + AddrWidth'(1);
            end
            if (x_q == LastX) begin
               x_q <= '0;
               y_q <= (y_q == LastY) ? '0 : y_q + YWidth'(1);
            end else begin
               x_q <= x_q + XWidth'(1);
            end
         end

         if (outFire) begin
            rdPtr_q <= ~rdPtr_q;
         end

         case (state_q)
            Fill: begin
               if (inFire) begin
                  if (waddr_q == LastAddr) begin
                     waddr_q <= '0;
                     state_q <= Drain;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                  end else begin
                     waddr_q <= waddr_q + AddrWidth'(1);
                  end
               end
            end
            Drain: begin
               // All reads are done by the time eof leaves, so restarting the
               // read side here cannot collide with an issue in this cycle.
               if (outFire && fifoEof_q[rdPtr_q]) begin
                  state_q    <= Fill;
                  ready_q    <= 1'b1;
                  busy_q     <= 1'b0;
                  raddr_q    <= '0;
                  readDone_q <= 1'b0;
                  x_q        <= '0;
                  y_q        <= '0;
               end
            end
            default: begin
               state_q <= Fill;
            end
         endcase
      end
   end

   assign bus.ready_o = ready_q;
   assign bus.busy_o  = busy_q;
   assign bus.valid_o = headValid;
   assign bus.data_o  = headValid ? fifoData_q[rdPtr_q] : '0;
   assign bus.sof_o   = headValid & fifoSof_q[rdPtr_q];
   assign bus.eol_o   = headValid & fifoEol_q[rdPtr_q];
   assign bus.eof_o   = headValid & fifoEof_q[rdPtr_q];

endmodule

// File: tb/tb_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_frame_streamer
// Directed bench for frame_streamer: a 4x3 instance (8-bit pixels) exercises
// capture, replay, backpressure, ignored writes during replay and reset in the
// middle of a replay; a 1x1 instance covers the single-pixel frame.
// -----------------------------------------------------------------------------
module tb_frame_streamer;

   logic clk;
   logic rstN;
   int   compared;
   int   mismatched;

   frame_streamer_if #(.WidthIn(8)) busA ();
   frame_streamer_if #(.WidthIn(8)) busB ();

   frame_streamer #(
      .LineWidthPx(4),
      .LineCountPx(3),
      .WidthIn    (8)
   ) dutA (
      .clk_i (clk),
      .rst_ni(rstN),
      .bus   (busA)
   );

   frame_streamer #(
      .LineWidthPx(1),
      .LineCountPx(1),
      .WidthIn    (8)
   ) dutB (
      .clk_i (clk),
      .rst_ni(rstN),
      .bus   (busB)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just after the rising edge, where outputs
   // are sampled and the next inputs are driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
      busA.valid_i = v;
      busA.data_i  = d;
      busA.ready_i = r;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected head for raster index k of the 4x3 frame whose pixels were base+k.
   task automatic checkPixel(input string tag, input int k, input int base);
      logic [7:0] expData;
      expData = 8'(base + k);
      checkOutput({tag, "_valid"}, 32'(busA.valid_o), 32'd1);
      checkOutput({tag, "_data"},  32'(busA.data_o),  32'(expData));
      checkOutput({tag, "_sof"},   32'(busA.sof_o),   32'(k == 0));
      checkOutput({tag, "_eol"},   32'(busA.eol_o),   32'((k % 4) == 3));
      checkOutput({tag, "_eof"},   32'(busA.eof_o),   32'(k == 11));
   endtask

   // Capture pixels base..base+11 one per cycle, then confirm DRAIN was
   // entered with nothing yet on the output.
   task automatic fillFrame(input string tag, input int base, input logic r, input logic holdHigh);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 8'(base + i), r);
         tick();
      end
      if (holdHigh) applyStimulus(1'b1, 8'hFF, r);
      else          applyStimulus(1'b0, 8'h00, r);
      checkOutput({tag, "_ready_low"}, 32'(busA.ready_o), 32'd0);
      checkOutput({tag, "_busy_high"}, 32'(busA.busy_o),  32'd1);
      checkOutput({tag, "_no_valid"},  32'(busA.valid_o), 32'd0);
   endtask

   // Stream the whole frame with ready_i high, one pixel per clock, then
   // confirm the block is back in FILL.
   task automatic drainCheck(input string tag, input int base);
      for (int k = 0; k < 12; k++) begin
         checkPixel(tag, k, base);
         tick();
      end
      checkOutput({tag, "_ready_back"}, 32'(busA.ready_o), 32'd1);
      checkOutput({tag, "_valid_gone"}, 32'(busA.valid_o), 32'd0);
      checkOutput({tag, "_busy_gone"},  32'(busA.busy_o),  32'd0);
   endtask

   initial begin
      logic [31:0] pat;
      int          expIdx;
      logic        rdy;

      compared   = 0;
      mismatched = 0;
      rstN       = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b1);
      busB.valid_i = 1'b0;
      busB.data_i  = 8'h00;
      busB.ready_i = 1'b1;

      // Reset values.
      tick();
      tick();
      checkOutput("rst_ready", 32'(busA.ready_o), 32'd1);
      checkOutput("rst_valid", 32'(busA.valid_o), 32'd0);
      checkOutput("rst_busy",  32'(busA.busy_o),  32'd0);
      checkOutput("rst_data",  32'(busA.data_o),  32'd0);
      checkOutput("rst_sof",   32'(busA.sof_o),   32'd0);
      checkOutput("rst_eol",   32'(busA.eol_o),   32'd0);
      checkOutput("rst_eof",   32'(busA.eof_o),   32'd0);
      rstN = 1'b1;
      tick();

      // Plain capture and replay: first valid two cycles after the last write.
      fillFrame("fill1", 0, 1'b1, 1'b0);
      tick();
      drainCheck("plain", 0);

      // Irregular backpressure: every valid cycle must show the next unsent
      // pixel, so a stall that changes the head or a drop/duplicate is caught.
      fillFrame("fill2", 0, 1'b1, 1'b0);
      pat    = 32'b1011_0010_0110_1001_1100_0101_0011_1010;
      expIdx = 0;
      for (int c = 0; c < 100 && expIdx < 12; c++) begin
         rdy          = pat[c % 32];
         busA.ready_i = rdy;
         if (busA.valid_o) begin
            checkPixel("bp", expIdx, 0);
            if (rdy) expIdx++;
         end
         tick();
      end
      checkOutput("bp_all_sent",   32'(expIdx),        32'd12);
      checkOutput("bp_ready_back", 32'(busA.ready_o),  32'd1);
      busA.ready_i = 1'b1;

      // Long stall throughout DRAIN, then release.
      fillFrame("fill3", 0, 1'b0, 1'b0);
      for (int c = 0; c < 20; c++) tick();
      checkOutput("stall_valid", 32'(busA.valid_o), 32'd1);
      checkOutput("stall_data",  32'(busA.data_o),  32'd0);
      checkOutput("stall_sof",   32'(busA.sof_o),   32'd1);
      checkOutput("stall_eol",   32'(busA.eol_o),   32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      drainCheck("release", 0);

      // valid_i held high with 0xFF during DRAIN must not corrupt the frame.
      fillFrame("fill4", 50, 1'b1, 1'b1);
      tick();
      for (int k = 0; k < 12; k++) begin
         checkPixel("hold", k, 50);
         checkOutput("hold_ready_low", 32'(busA.ready_o), 32'd0);
         tick();
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("hold_ready_back", 32'(busA.ready_o), 32'd1);
      fillFrame("fill5", 100, 1'b1, 1'b0);
      tick();
      drainCheck("second", 100);

      // Asynchronous reset after six pixels of a replay.
      fillFrame("fill6", 200, 1'b1, 1'b0);
      tick();
      for (int k = 0; k < 6; k++) begin
         checkPixel("pre_rst", k, 200);
         tick();
      end
      rstN = 1'b0;
      #1;
      checkOutput("arst_valid", 32'(busA.valid_o), 32'd0);
      checkOutput("arst_ready", 32'(busA.ready_o), 32'd1);
      checkOutput("arst_busy",  32'(busA.busy_o),  32'd0);
      tick();
      rstN = 1'b1;
      tick();
      fillFrame("fill7", 30, 1'b1, 1'b0);
      tick();
      drainCheck("post_rst", 30);

      // Single-pixel frame on the 1x1 instance.
      busB.valid_i = 1'b1;
      busB.data_i  = 8'h5A;
      tick();
      busB.valid_i = 1'b0;
      busB.data_i  = 8'h00;
      checkOutput("one_ready_low", 32'(busB.ready_o), 32'd0);
      checkOutput("one_busy",      32'(busB.busy_o),  32'd1);
      checkOutput("one_no_valid",  32'(busB.valid_o), 32'd0);
      tick();
      checkOutput("one_valid", 32'(busB.valid_o), 32'd1);
      checkOutput("one_data",  32'(busB.data_o),  32'h5A);
      checkOutput("one_sof",   32'(busB.sof_o),   32'd1);
      checkOutput("one_eol",   32'(busB.eol_o),   32'd1);
      checkOutput("one_eof",   32'(busB.eof_o),   32'd1);
      tick();
      checkOutput("one_ready_back", 32'(busB.ready_o), 32'd1);
      checkOutput("one_valid_gone", 32'(busB.valid_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
